// File: rtl/lvds_rx_pkg.sv
// Shared constants for the LVDS ping-pong frame receiver: FSM encoding,
// status word bit positions and bank select values.
package lvds_rx_pkg;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FILL  = 3'd1;
    localparam logic [2:0] S_FLUSH = 3'd2;
    localparam logic [2:0] S_FULL  = 3'd3;
    localparam logic [2:0] S_SWAP  = 3'd4;
    localparam logic [2:0] S_DROP  = 3'd5;

    localparam int ST_FULL_A = 0;
    localparam int ST_FULL_B = 1;
    localparam int ST_OVR    = 2;
    localparam int ST_TRUNC  = 3;
    localparam int ST_ACT    = 4;
    localparam int ST_BUSY   = 5;

    localparam logic BANK_A = 1'b0;
    localparam logic BANK_B = 1'b1;
endpackage

// File: rtl/lvds_sync_edge.sv
// N-bit two-flop synchroniser; the low EDGE_W bits also get a third stage
// for single-cycle rise/fall pulses.
module lvds_sync_edge #(
    parameter int N      = 1,
    parameter int EDGE_W = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      d,
    output logic [N-1:0]      q,
    output logic [EDGE_W-1:0] rise,
    output logic [EDGE_W-1:0] fall
);
    logic [N-1:0]      s1, s2;
    logic [EDGE_W-1:0] s3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2[EDGE_W-1:0];
        end
    end

    assign q    = s2;
    assign rise = s2[EDGE_W-1:0] & ~s3;
    assign fall = ~s2[EDGE_W-1:0] & s3;
endmodule

// File: rtl/lvds_rx_pingpong.sv
// Source-synchronous LVDS frame receiver into a two-bank ping-pong buffer.
// Optional LVDS_RX_FRAMECNT_EN adds a 2-bit completed-frame counter in STATE[7:6].
module lvds_rx_pingpong
    import lvds_rx_pkg::*;
#(
    parameter int LANES  = 1,
    parameter int WORD_W = 32,
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              LVDS_VS,
    input  logic              LVDS_CLK,
    input  logic [LANES-1:0]  LVDS_DATA,
    input  logic [ADDR_W:0]   EU_LVDS_BUF_ADDR,
    output logic [WORD_W-1:0] EU_LVDS_BUF_DATA,
    output logic [7:0]        LVDS_EU_STATE,
    output logic [ADDR_W:0]   LVDS_EU_WCNT_A,
    output logic [ADDR_W:0]   LVDS_EU_WCNT_B,
    input  logic              LVDS_STATE_CLEAR_CS,
    input  logic [7:0]        LVDS_STATE_CLEAR
);
    localparam int SPW  = WORD_W / LANES;
    localparam int BC_W = $clog2(SPW + 1);

    logic [LANES+1:0] sync_q;
    logic [1:0]       rise, fall;
    logic             vs_lvl, vs_rise, vs_fall, clk_rise;
    logic [LANES-1:0] din;

    lvds_sync_edge #(.N(LANES + 2), .EDGE_W(2)) u_sync (
        .clk  (CLK),
        .rst  (RST),
        .d    ({LVDS_DATA, LVDS_CLK, LVDS_VS}),
        .q    (sync_q),
        .rise (rise),
        .fall (fall)
    );

    assign vs_lvl   = sync_q[0];
    assign vs_rise  = rise[0];
    assign vs_fall  = fall[0];
    assign clk_rise = rise[1];
    assign din      = sync_q[LANES+1:2];

    logic unused_bits;
    assign unused_bits = ^{sync_q[1], fall[1], LVDS_STATE_CLEAR[7:4]};

    logic [2:0]        state;
    logic              act;
    logic [ADDR_W:0]   waddr;
    logic [BC_W-1:0]   bitcnt;
    logic [WORD_W-1:0] shreg;
    logic [ADDR_W:0]   wcnt_a, wcnt_b;
    logic              full_a, full_b, ovr, trunc;
    logic [1:0]        settle;
    logic              armed;
    logic              word_done, busy, act_full;
    logic [WORD_W-1:0] shifted, padded;

    assign word_done = (bitcnt == BC_W'(SPW - 1));
    assign shifted   = (shreg << LANES) | WORD_W'(din);
    // partial word: left-justify the collected samples, zeros below
    assign padded    = shreg << (WORD_W - int'(bitcnt) * LANES);
    assign act_full  = (act == BANK_A) ? full_a : full_b;
    assign busy      = (state == S_FILL) || (state == S_FLUSH) ||
                       (state == S_FULL) || (state == S_DROP);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= S_IDLE;
            act    <= BANK_A;
            waddr  <= '0;
            bitcnt <= '0;
            shreg  <= '0;
            wcnt_a <= '0;
            wcnt_b <= '0;
            full_a <= 1'b0;
            full_b <= 1'b0;
            ovr    <= 1'b0;
            trunc  <= 1'b0;
            settle <= '0;
            armed  <= 1'b0;
        end else begin
            // a frame already running at reset release is skipped: wait for VS low first
            if (settle != 2'd3) settle <= settle + 2'd1;
            if (settle == 2'd3 && !vs_lvl) armed <= 1'b1;

            // clears first so that FSM sets later in this block take priority
            if (LVDS_STATE_CLEAR_CS) begin
                if (LVDS_STATE_CLEAR[ST_FULL_A]) full_a <= 1'b0;
                if (LVDS_STATE_CLEAR[ST_FULL_B]) full_b <= 1'b0;
                if (LVDS_STATE_CLEAR[ST_OVR])    ovr    <= 1'b0;
                if (LVDS_STATE_CLEAR[ST_TRUNC])  trunc  <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (vs_rise && armed) begin
                        waddr  <= '0;
                        bitcnt <= '0;
                        shreg  <= '0;
                        if (act_full) begin
                            ovr   <= 1'b1;
                            state <= S_DROP;
                        end else begin
                            state <= S_FILL;
                        end
                    end
                end
                S_FILL: begin
                    if (clk_rise) begin
                        if (word_done) begin
                            bitcnt <= '0;
                            shreg  <= '0;
                            if (!waddr[ADDR_W]) waddr <= waddr + 1'b1;
                        end else begin
                            bitcnt <= bitcnt + 1'b1;
                            shreg  <= shifted;
                        end
                    end
                    if (vs_fall)            state <= S_FLUSH;
                    else if (waddr[ADDR_W]) state <= S_FULL;
                end
                S_FLUSH: begin
                    if (bitcnt != '0) waddr <= waddr + 1'b1;
                    state <= S_SWAP;
                end
                S_FULL: begin
                    trunc <= 1'b1;
                    if (vs_fall) state <= S_SWAP;
                end
                S_SWAP: begin
                    if (act == BANK_A) begin
                        wcnt_a <= waddr;
                        full_a <= 1'b1;
                    end else begin
                        wcnt_b <= waddr;
                        full_b <= 1'b1;
                    end
                    act    <= ~act;
                    waddr  <= '0;
                    bitcnt <= '0;
                    state  <= S_IDLE;
                end
                S_DROP: begin
                    ovr <= 1'b1;
                    if (vs_fall) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    logic [1:0] frame_cnt;
`ifdef LVDS_RX_FRAMECNT_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)                                            frame_cnt <= 2'd0;
        else if (state == S_SWAP)                           frame_cnt <= frame_cnt + 2'd1;
        else if (LVDS_STATE_CLEAR_CS && LVDS_STATE_CLEAR[7]) frame_cnt <= 2'd0;
    end
`else
    assign frame_cnt = 2'd0;
`endif

    logic              mem_we;
    logic [WORD_W-1:0] mem_wd;
    logic [ADDR_W:0]   mem_wa;
    logic [WORD_W-1:0] mem [0:2*DEPTH-1];

    always_comb begin
        mem_we = 1'b0;
        mem_wd = shifted;
        if (state == S_FILL && clk_rise && word_done && !waddr[ADDR_W]) begin
            mem_we = 1'b1;
        end else if (state == S_FLUSH && bitcnt != '0) begin
            mem_we = 1'b1;
            mem_wd = padded;
        end
    end
    assign mem_wa = {act, waddr[ADDR_W-1:0]};

    always_ff @(posedge CLK) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
        EU_LVDS_BUF_DATA <= mem[EU_LVDS_BUF_ADDR];
    end

    assign LVDS_EU_STATE  = {frame_cnt, busy, act, trunc, ovr, full_b, full_a};
    assign LVDS_EU_WCNT_A = wcnt_a;
    assign LVDS_EU_WCNT_B = wcnt_b;
endmodule
